mdu_seq: RTL
============

Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer owning the HI/LO register pair.
- Executes the multi-cycle MULT/MULTU/DIV/DIVU operations that the ALU does not compute itself; ALU_OPT_MULT ops are routed here by stage_ex.
- Also handles MTHI/MTLO writes.
- stage_ex starts an operation, stalls on busy, and reads hi/lo directly.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request; accepted only when state is IDLE and flush=0
op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
opr1  input  WIDTH  multiplicand/dividend; MTHI/MTLO data
opr2  input  WIDTH  multiplier/divisor
flush  input  1  synchronous abort of the in-flight operation
busy  output  1  high while state is CALC or FIX
done  output  1  one-cycle completion pulse
div_by_zero  output  1  pulses with done when a divisor of 0 was given
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset (rst_n=0 at an edge), from any state including mid-operation: state=IDLE; hi=lo=0; busy=0; done=0; div_by_zero=0; iteration counter=0.
- State machine:
  - States: IDLE, CALC, FIX.
  - IDLE + start accepted + op in 0..3, divisor nonzero: latch |opr1|, |opr2| (absolute values only for signed ops 0/2); latch result sign = opr1[31]^opr2[31]; latch remainder sign = opr1[31] (DIV only). Go to CALC with count=0.
  - CALC: one radix-2 step per cycle.
    - Multiply: shift-add into a 2*WIDTH accumulator.
    - Divide: restoring shift-subtract producing quotient and remainder.
    - After WIDTH steps (count = WIDTH-1 at the edge), go to FIX.
  - FIX: apply two's-complement negation.
    - Signed MULT: negate the 64-bit product if the result sign is set.
    - DIV: negate the quotient if the result sign is set; negate the remainder if the remainder sign is set.
    - Write hi/lo. Go to IDLE; done=1 for the next cycle.
- Results:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH product.
  - DIV/DIVU: lo = quotient, hi = remainder; signed division truncates toward zero.
  - DIV 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0. This falls out of unsigned magnitude handling and needs no special case.
- Latency for ops 0-3:
  - Start accepted at edge E0; busy=1 from E0 to E0+33 (33 cycles high).
  - hi/lo updated and done=1 in the cycle following edge E0+33.
  - done is high while state is already IDLE, so a new start is accepted in the same cycle as done.
- Divide by zero (DIV/DIVU, opr2=0): no iteration; hi/lo unchanged; done=1 and div_by_zero=1 in the cycle after acceptance; busy stays 0.
- MTHI/MTLO: hi (resp. lo) = opr1 at the accepting edge; done=1 the next cycle; busy stays 0.
- Reserved op 6-7: ignored. No state change, no done.
- start while busy=1: ignored; inputs are not re-latched. stage_ex must hold its request until busy=0.
- Operands are latched at acceptance; opr1/opr2 changes during CALC have no effect.
- hi/lo hold their previous values throughout CALC/FIX and change only at the FIX edge, on an MTHI/MTLO acceptance, or on reset.
- flush=1 at an edge, in any state:
  - state=IDLE, busy=0, counter=0; no done pulse; hi/lo unchanged.
  - flush and start in the same cycle: flush wins and start is dropped, including MTHI/MTLO.
  - flush in the FIX cycle: the hi/lo write is suppressed.
- done and div_by_zero are registered pulses and are never high for two consecutive cycles from a single operation.

Test Plan:
1. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy high exactly 33 cycles; done after 34; hi=0xFFFFFFFE, lo=0x00000001. Back-to-back start in the done cycle is accepted.
2. MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
3. DIVU 100/7 -> lo=14, hi=2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
4. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 with hi=0x11, lo=0x22 beforehand -> done and div_by_zero high one cycle after start; busy never high; hi/lo unchanged.
5. MTHI 0xDEADBEEF then MTLO 0x12345678 on consecutive cycles -> each done one cycle later, busy=0; hi=0xDEADBEEF, lo=0x12345678. op=6 -> no done.
6. Flush and reset mid-operation:
   - MULT started, flush at cycle 10 -> busy=0 next cycle, no done, hi/lo keep old values; start asserted with flush in the same cycle is dropped.
   - rst_n=0 at cycle 20 of DIV -> busy=0, done=0, hi=lo=0 after that edge.

Source files
------------

// File: rtl/mdu_seq.sv
// Iterative radix-2 multiply/divide sequencer that owns the HI/LO pair.
// One shift-add or restoring shift-subtract step per cycle, then a sign-fix cycle.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opr1,
  input  logic [WIDTH-1:0] opr2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~$unsigned(v) + 1'b1) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic               is_div;
  logic               res_neg;
  logic               rem_neg;

  logic signed [WIDTH-1:0] s1;
  logic signed [WIDTH-1:0] s2;
  logic               signed_op;
  logic               div_op;
  logic               arith_op;
  logic               zero_div;
  logic               accept;
  logic               load;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;

  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     dsub;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign s1        = opr1;
  assign s2        = opr2;
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign div_op    = (op == OP_DIV) || (op == OP_DIVU);
  assign arith_op  = (op[2] == 1'b0);
  assign zero_div  = div_op && (opr2 == '0);
  assign accept    = start && (state == IDLE) && !flush;
  assign load      = accept && arith_op && !zero_div;
  assign mag1      = signed_op ? abs_mag(s1) : opr1;
  assign mag2      = signed_op ? abs_mag(s2) : opr2;

  // Multiply: acc low half starts as the multiplier and is consumed LSB first.
  assign msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  assign mul_next = {msum, acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; quotient bits shift in at the bottom.
  assign trial    = acc[2*WIDTH-1:WIDTH-1];
  assign dsub     = trial - {1'b0, opb};
  assign div_next = dsub[WIDTH] ? {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {dsub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign prod_fix = cond_neg_2w(acc, res_neg);
  assign quo_fix  = cond_neg_w(acc[WIDTH-1:0], res_neg);
  assign rem_fix  = cond_neg_w(acc[2*WIDTH-1:WIDTH], rem_neg);

  assign busy = (state == CALC) || (state == FIX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (flush) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              case (op)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                  if (zero_div) begin
                    done        <= 1'b1;
                    div_by_zero <= 1'b1;
                  end else begin
                    state <= CALC;
                    cnt   <= '0;
                  end
                end
                OP_MTHI: begin
                  hi   <= opr1;
                  done <= 1'b1;
                end
                OP_MTLO: begin
                  lo   <= opr1;
                  done <= 1'b1;
                end
                default: ;
              endcase
            end
          end
          CALC: begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
          end
          FIX: begin
            if (is_div) begin
              lo <= quo_fix;
              hi <= rem_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    if (load) begin
      is_div  <= div_op;
      res_neg <= signed_op && (opr1[WIDTH-1] ^ opr2[WIDTH-1]);
      rem_neg <= (op == OP_DIV) && opr1[WIDTH-1];
      if (div_op) begin
        acc <= {{WIDTH{1'b0}}, mag1};
        opb <= mag2;
      end else begin
        acc <= {{WIDTH{1'b0}}, mag2};
        opb <= mag1;
      end
    end else if ((state == CALC) && !flush) begin
      acc <= is_div ? div_next : mul_next;
    end
  end

endmodule
